galpal_fuse_loader: RTL and testbench
=====================================

Name: galpal_fuse_loader

Overview:
- Configuration controller for the galpal_22V10 fuse-map model.
- Accepts a JEDEC-order fuse stream as bytes over a valid/ready handshake and assembles it into a shadow fuse array.
- Accumulates the standard JEDEC 16-bit fuse checksum, compares it against an expected value, and commits the shadow array to the FUSE output only on a match.
- FUSE drives a 22V10 instance as its live fuse map, so a bad or partial load never reaches the device.

Parameters:
- FUSE_COUNT, 5892, number of fuse bits in the map (22V10 map size).
- NWORDS, ceil(FUSE_COUNT/8) = 737, derived; bytes per map.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- START  in  1  pulse; begins a new load.
- DIN  in  8  fuse byte; bit b of byte k is fuse[8k+b].
- DIN_VALID  in  1  DIN holds a valid byte.
- DIN_READY  out  1  loader accepts DIN this cycle.
- CSUM_EXP  in  16  expected JEDEC checksum; sampled in CHECK.
- CSUM  out  16  running or final checksum.
- FUSE  out  FUSE_COUNT  committed fuse map.
- FUSE_VALID  out  1  FUSE holds a verified map.
- BUSY  out  1  state is LOAD or CHECK.
- DONE  out  1  one-cycle pulse on successful commit.
- ERR  out  1  sticky checksum failure; cleared by START or RST.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous, active-high, and has priority over all other inputs.
- Reset values:
  - state = IDLE
  - FUSE = all ones (erased map); shadow = all ones
  - FUSE_VALID = 0, DIN_READY = 0, BUSY = 0, DONE = 0, ERR = 0, CSUM = 0
  - word counter = 0
- States: IDLE, LOAD, CHECK.
- IDLE:
  - DIN_READY = 0.
  - START -> LOAD next cycle; counter = 0, CSUM = 0, ERR = 0.
  - FUSE and FUSE_VALID keep their values.
- LOAD:
  - DIN_READY = 1. A transfer happens when DIN_VALID && DIN_READY.
  - On a transfer: write shadow[8k+7:8k] = masked DIN; CSUM <= CSUM + masked DIN (mod 2^16); counter += 1.
  - Masking: bits with index 8k+b >= FUSE_COUNT are forced to 0 for both storage and checksum. For the last byte (k = 736) only bits 3:0 are kept.
  - Transfer of byte NWORDS-1 -> CHECK next cycle.
  - DIN_VALID low: stall, no state change, no timeout.
- CHECK (one cycle):
  - DIN_READY = 0.
  - If CSUM == CSUM_EXP: FUSE <= shadow, FUSE_VALID <= 1, DONE pulses in the cycle after CHECK, -> IDLE.
  - Otherwise: ERR <= 1, FUSE and FUSE_VALID unchanged, -> IDLE.
- Latency: DONE/ERR visible 2 cycles after the final byte's handshake edge.
- START while in LOAD or CHECK: abort and restart; counter = 0, CSUM = 0, ERR = 0.
  - START in the same cycle as DIN_VALID: START wins; DIN_READY is held low that cycle, so no byte is consumed.
- FUSE_VALID is cleared at the START that begins any load. FUSE keeps its old contents until a successful commit.
- RST mid-load: state returns to IDLE with reset values. The partial shadow is discarded (re-erased to all ones).
- Counter: 10 bits, saturates at the CHECK transition and never wraps.
- CSUM stays visible after CHECK until the next START.
- The shadow is rewritten byte by byte during LOAD; it is not cleared at START. Every shadow bit is overwritten before CHECK.

Decomposition:
- Shared include galpal_defs.vh holds:
  - GALPAL_22V10_FUSES = 5892
  - state encodings LDR_IDLE/LDR_LOAD/LDR_CHECK
  - the JEDEC checksum width (16)
- Natural sub-module galpal_fuse_csum: 16-bit accumulator with clear, 8-bit masked add-enable, and a compare-equal output. Reusable for other device maps.

Test Plan:
- Zero map: RST, START, 737 bytes of 0x00 back-to-back, CSUM_EXP = 0x0000 -> DONE pulse, FUSE all zero, FUSE_VALID = 1, ERR = 0, DONE 2 cycles after the last handshake.
- Full-ones map: 737 bytes of 0xFF, CSUM_EXP = 0xDD2F -> CSUM = 0xDD2F (736*0xFF + 0x0F), FUSE all ones, DONE. Checks masking of last-byte bits 7:4.
- Checksum mismatch: load pattern byte k = k[7:0] with wrong CSUM_EXP -> ERR = 1, FUSE and FUSE_VALID keep the prior good map, no DONE.
- Backpressure/stall: drive DIN_VALID randomly (~50%) during a 0xA5 load -> exactly 737 bytes consumed, FUSE[7:0] = 8'hA5, FUSE[5891:5888] = 4'h5.
- Abort: START again after byte 300, with DIN_VALID high in the same cycle -> DIN_READY = 0 that cycle, counter restarts, FUSE_VALID = 0, and a subsequent full good load commits correctly.
- Reset mid-load: assert RST after byte 100 -> next cycle all outputs at reset values, FUSE all ones; the following START/load completes normally.

Source files
------------

// File: rtl/galpal_fuse_loader_pkg.sv
// Shared constants and types for the 22V10 fuse-map loader.
package galpal_fuse_loader_pkg;
  localparam int GALPAL_22V10_FUSES = 5892;
  localparam int FUSE_COUNT         = GALPAL_22V10_FUSES;
  localparam int NWORDS             = (FUSE_COUNT + 7) / 8;
  localparam int CSUM_W             = 16;
  localparam int CNT_W              = 10;

  typedef enum logic [1:0] {
    LDR_IDLE  = 2'd0,
    LDR_LOAD  = 2'd1,
    LDR_CHECK = 2'd2
  } ldr_state_t;

  // Keep only the bits of byte k that land inside the fuse map.
  function automatic logic [7:0] byte_mask(input logic [CNT_W-1:0] k);
    logic [7:0] m;
    for (int b = 0; b < 8; b++) begin
      m[b] = ((int'(k) * 8 + b) < FUSE_COUNT);
    end
    return m;
  endfunction
endpackage

// File: rtl/galpal_fuse_loader_if.sv
// Bus between a fuse-stream source (master) and the loader (slave).
// Handshake: a byte moves on a rising CLK edge when DIN_VALID and DIN_READY
// are both high in the preceding cycle; DIN_VALID may drop at any time and
// DIN_READY is low whenever START is high.
interface galpal_fuse_loader_if;
  import galpal_fuse_loader_pkg::*;

  logic                  START;
  logic [7:0]            DIN;
  logic                  DIN_VALID;
  logic                  DIN_READY;
  logic [CSUM_W-1:0]     CSUM_EXP;
  logic [CSUM_W-1:0]     CSUM;
  logic [FUSE_COUNT-1:0] FUSE;
  logic                  FUSE_VALID;
  logic                  BUSY;
  logic                  DONE;
  logic                  ERR;
  ldr_state_t            STATE;

  modport master (
    output START, DIN, DIN_VALID, CSUM_EXP,
    input  DIN_READY, CSUM, FUSE, FUSE_VALID, BUSY, DONE, ERR, STATE
  );

  modport slave (
    input  START, DIN, DIN_VALID, CSUM_EXP,
    output DIN_READY, CSUM, FUSE, FUSE_VALID, BUSY, DONE, ERR, STATE
  );
endinterface

// File: rtl/galpal_fuse_csum.sv
// 16-bit JEDEC-style byte-sum accumulator with clear and compare-equal.
module galpal_fuse_csum
  import galpal_fuse_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_add_en,
  input  logic [7:0]        i_din,
  input  logic [7:0]        i_mask,
  input  logic [CSUM_W-1:0] i_exp,
  output logic [CSUM_W-1:0] o_sum,
  output logic              o_eq
);
  logic [CSUM_W-1:0] r_sum;
  logic [7:0]        w_masked;

  assign w_masked = i_din & i_mask;

  // Running sum modulo 2^16; clear wins over add.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sum <= '0;
    end else if (i_clr) begin
      r_sum <= '0;
    end else if (i_add_en) begin
      r_sum <= r_sum + {{(CSUM_W-8){1'b0}}, w_masked};
    end
  end

  assign o_sum = r_sum;
  assign o_eq  = (r_sum == i_exp);
endmodule

// File: rtl/galpal_fuse_loader.sv
// Loads a JEDEC-order fuse stream into a shadow map and commits it to FUSE
// only when the accumulated checksum matches CSUM_EXP.
module galpal_fuse_loader
  import galpal_fuse_loader_pkg::*;
(
  input logic                 CLK,
  input logic                 RST,
  galpal_fuse_loader_if.slave bus
);
  ldr_state_t            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [FUSE_COUNT-1:0] r_shadow;
  logic [FUSE_COUNT-1:0] r_fuse;
  logic                  r_fuse_valid;
  logic                  r_done;
  logic                  r_err;

  logic                  w_din_ready;
  logic                  w_xfer;
  logic                  w_last;
  logic [7:0]            w_mask;
  logic [CSUM_W-1:0]     w_csum;
  logic                  w_csum_eq;
  logic [FUSE_COUNT-1:0] w_byte_we;
  logic [FUSE_COUNT-1:0] w_byte_data;

  // START takes the cycle, so no byte is consumed alongside it.
  assign w_din_ready = (r_state == LDR_LOAD) && !bus.START;
  assign w_xfer      = w_din_ready && bus.DIN_VALID;
  assign w_last      = (r_cnt == CNT_W'(NWORDS - 1));
  assign w_mask      = byte_mask(r_cnt);

  // Byte lane k of the map; shifting past the top drops the out-of-map bits.
  assign w_byte_we   = {{(FUSE_COUNT-8){1'b0}}, 8'hFF}   << {r_cnt, 3'b000};
  assign w_byte_data = {{(FUSE_COUNT-8){1'b0}}, bus.DIN} << {r_cnt, 3'b000};

  galpal_fuse_csum u_csum (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_clr    (bus.START),
    .i_add_en (w_xfer),
    .i_din    (bus.DIN),
    .i_mask   (w_mask),
    .i_exp    (bus.CSUM_EXP),
    .o_sum    (w_csum),
    .o_eq     (w_csum_eq)
  );

  // Load FSM: IDLE -> LOAD (byte collection) -> CHECK (commit or flag) -> IDLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= LDR_IDLE;
      r_cnt        <= '0;
      r_shadow     <= '1;
      r_fuse       <= '1;
      r_fuse_valid <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.START) begin
        r_state      <= LDR_LOAD;
        r_cnt        <= '0;
        r_err        <= 1'b0;
        r_fuse_valid <= 1'b0;
      end else begin
        case (r_state)
          LDR_IDLE: begin
            r_state <= LDR_IDLE;
          end
          LDR_LOAD: begin
            if (w_xfer) begin
              r_shadow <= (r_shadow & ~w_byte_we) | w_byte_data;
              r_cnt    <= r_cnt + 1'b1;
              if (w_last) begin
                r_state <= LDR_CHECK;
              end
            end
          end
          LDR_CHECK: begin
            if (w_csum_eq) begin
              r_fuse       <= r_shadow;
              r_fuse_valid <= 1'b1;
              r_done       <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
            r_state <= LDR_IDLE;
          end
          default: begin
            r_state <= LDR_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.DIN_READY  = w_din_ready;
  assign bus.CSUM       = w_csum;
  assign bus.FUSE       = r_fuse;
  assign bus.FUSE_VALID = r_fuse_valid;
  assign bus.BUSY       = (r_state != LDR_IDLE);
  assign bus.DONE       = r_done;
  assign bus.ERR        = r_err;
  assign bus.STATE      = r_state;
endmodule

// File: tb/tb_galpal_fuse_loader.sv
// Bench for galpal_fuse_loader: scoreboard of expected load outcomes,
// popped by a monitor whenever DONE pulses or ERR rises.
`timescale 1ns/1ps
module tb_galpal_fuse_loader;
  import galpal_fuse_loader_pkg::*;

  localparam int EXP_W = 2 + CSUM_W + FUSE_COUNT;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  galpal_fuse_loader_if bus ();

  galpal_fuse_loader dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]            stim [NWORDS];
  logic [FUSE_COUNT-1:0] m_fuse;
  logic [EXP_W-1:0]      exp_q [$];
  time                   last_hs_time;
  int                    events_seen = 0;
  int                    events_pushed = 0;

  // Sum of the in-map part of every byte, reduced modulo 2^16.
  function automatic logic [15:0] model_csum();
    int s = 0;
    for (int k = 0; k < NWORDS; k++)
      for (int b = 0; b < 8; b++)
        if ((k * 8 + b) < FUSE_COUNT && stim[k][b])
          s += (1 << b);
    return 16'(s % 65536);
  endfunction

  // Fuse i is bit (i mod 8) of byte (i div 8).
  function automatic logic [FUSE_COUNT-1:0] model_map();
    logic [FUSE_COUNT-1:0] m;
    for (int i = 0; i < FUSE_COUNT; i++) begin
      logic [7:0] bt;
      bt   = stim[i / 8];
      m[i] = bt[i % 8];
    end
    return m;
  endfunction

  task automatic fill(input int mode);
    for (int k = 0; k < NWORDS; k++) begin
      case (mode)
        0:       stim[k] = 8'h00;
        1:       stim[k] = 8'hFF;
        2:       stim[k] = 8'(k);
        3:       stim[k] = 8'hA5;
        default: stim[k] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  // Record the outcome the coming full load must produce.
  task automatic push_expect(input logic [15:0] csum_exp);
    logic [15:0] s;
    logic        ok;
    s  = model_csum();
    ok = (s == csum_exp);
    if (ok) m_fuse = model_map();
    exp_q.push_back({!ok, ok, s, m_fuse});
    events_pushed++;
  endtask

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_fuse(input string name, input logic [FUSE_COUNT-1:0] act,
                          input logic [FUSE_COUNT-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual[31:0]=%h required[31:0]=%h, %0d bits differ",
               name, act[31:0], req[31:0], $countones(act ^ req));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"},      64'(bus.STATE), 64'(LDR_IDLE));
    chk({tag, "_fuse_valid"}, 64'(bus.FUSE_VALID), 64'd0);
    chk({tag, "_din_ready"},  64'(bus.DIN_READY), 64'd0);
    chk({tag, "_busy"},       64'(bus.BUSY), 64'd0);
    chk({tag, "_done"},       64'(bus.DONE), 64'd0);
    chk({tag, "_err"},        64'(bus.ERR), 64'd0);
    chk({tag, "_csum"},       64'(bus.CSUM), 64'd0);
    chk_fuse({tag, "_fuse"},  bus.FUSE, {FUSE_COUNT{1'b1}});
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic pulse_start();
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
  endtask

  task automatic drive_bytes(input int n, input bit stall);
    int  k = 0;
    int  budget = 0;
    logic acc;
    while (k < n) begin
      bus.DIN       = stim[k];
      bus.DIN_VALID = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      acc = bus.DIN_VALID && bus.DIN_READY;
      @(posedge clk);
      if (acc) begin
        last_hs_time = $time;
        k++;
      end
      @(negedge clk);
      budget++;
      if (budget > 8000) begin
        chk("drive_timeout_bytes", 64'(k), 64'(n));
        break;
      end
    end
    bus.DIN_VALID = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_result_pending"}, 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic run_load(input string name, input logic [15:0] csum_exp, input bit stall);
    bus.CSUM_EXP = csum_exp;
    push_expect(csum_exp);
    pulse_start();
    drive_bytes(NWORDS, stall);
    wait_result(name);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic prev_err  = 1'b0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_err  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("done_one_cycle", 64'(bus.DONE), 64'd0);
      if (bus.DONE || (bus.ERR && !prev_err)) begin
        events_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_event_done_err", {62'd0, bus.DONE, bus.ERR}, 64'd0);
        end else begin
          logic [EXP_W-1:0] e;
          e = exp_q.pop_front();
          chk("sb_err",        64'(bus.ERR),        64'(e[EXP_W-1]));
          chk("sb_done",       64'(bus.DONE),       64'(!e[EXP_W-1]));
          chk("sb_fuse_valid", 64'(bus.FUSE_VALID), 64'(e[EXP_W-2]));
          chk("sb_csum",       64'(bus.CSUM),       64'(e[EXP_W-3 -: 16]));
          chk_fuse("sb_fuse",  bus.FUSE,            e[FUSE_COUNT-1:0]);
          chk("sb_latency",    64'($time - last_hs_time), 64'd15);
          chk("sb_idle",       64'(bus.BUSY),       64'd0);
        end
      end
      prev_err  = bus.ERR;
      prev_done = bus.DONE;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] s;
    rst           = 1'b1;
    bus.START     = 1'b0;
    bus.DIN       = 8'h00;
    bus.DIN_VALID = 1'b0;
    bus.CSUM_EXP  = 16'h0000;
    m_fuse        = '1;
    last_hs_time  = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

    // zero map
    fill(0);
    run_load("zero", 16'h0000, 1'b0);
    chk_fuse("zero_fuse", bus.FUSE, '0);

    // full-ones map: last byte keeps only bits 3:0
    fill(1);
    run_load("ones", 16'hDD2F, 1'b0);
    chk("ones_csum", 64'(bus.CSUM), 64'h0000_DD2F);
    chk_fuse("ones_fuse", bus.FUSE, '1);

    // checksum mismatch: prior map kept, FUSE_VALID cleared by START
    fill(2);
    s = model_csum();
    run_load("mismatch", s ^ 16'h0100, 1'b0);
    chk_fuse("mismatch_fuse_kept", bus.FUSE, '1);
    chk("mismatch_fuse_valid", 64'(bus.FUSE_VALID), 64'd0);

    // backpressure: random DIN_VALID
    fill(3);
    run_load("stall", model_csum(), 1'b1);
    chk("stall_low_byte", 64'(bus.FUSE[7:0]), 64'hA5);
    chk("stall_top_nibble", 64'(bus.FUSE[FUSE_COUNT-1 -: 4]), 64'h5);

    // abort after byte 300 with DIN_VALID high alongside START
    fill(4);
    pulse_start();
    drive_bytes(301, 1'b0);
    chk("pre_abort_busy", 64'(bus.BUSY), 64'd1);
    bus.START     = 1'b1;
    bus.DIN_VALID = 1'b1;
    bus.DIN       = stim[301];
    #1;
    chk("abort_din_ready", 64'(bus.DIN_READY), 64'd0);
    @(negedge clk);
    bus.START     = 1'b0;
    bus.DIN_VALID = 1'b0;
    chk("abort_fuse_valid", 64'(bus.FUSE_VALID), 64'd0);
    chk("abort_csum", 64'(bus.CSUM), 64'd0);
    chk("abort_state", 64'(bus.STATE), 64'(LDR_LOAD));
    fill(4);
    bus.CSUM_EXP = model_csum();
    push_expect(bus.CSUM_EXP);
    drive_bytes(NWORDS, 1'b1);
    wait_result("after_abort");

    // reset mid-load after byte 100
    fill(4);
    bus.CSUM_EXP = 16'h1234;
    pulse_start();
    drive_bytes(101, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midload_rst");
    m_fuse = '1;
    rst = 1'b0;
    @(negedge clk);

    // recovery loads: one good, one random mismatch, one good
    for (int t = 0; t < 3; t++) begin
      fill(4);
      s = model_csum();
      if (t == 1) s = s + 16'(1 + $urandom_range(0, 100));
      run_load("random", s, 1'($urandom_range(0, 1)));
    end

    chk("events_seen", 64'(events_seen), 64'(events_pushed));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
